// File: rtl/mul_io_sequencer.sv
// Operand/result sequencer between a word-wide valid/ready stream and the array multiplier.
// Optional WAIT watchdog with sticky err: define MUL_SEQ_TIMEOUT_EN.
module mul_io_sequencer #(
    parameter int W       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W-1:0]   mul_a,
    output logic [W-1:0]   mul_b,
    output logic           mul_start,
    input  logic           mul_done,
    input  logic [2*W-1:0] mul_p,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy,
    output logic           err
);

    typedef enum logic [2:0] {
        S_LOAD_A, S_LOAD_B, S_START, S_WAIT, S_OUT_LO, S_OUT_HI
    } state_t;

    state_t         r_state;
    state_t         w_nxt;
    logic [2*W-1:0] r_prod;
    logic [W-1:0]   r_mul_a;
    logic [W-1:0]   r_mul_b;
    logic [W-1:0]   r_out_data;
    logic           r_in_ready;
    logic           r_mul_start;
    logic           r_out_valid;
    logic           r_busy;
    logic           w_acc;
    logic           w_tmo;

    assign w_acc = in_valid & r_in_ready;

`ifdef MUL_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    logic          r_err;

    // Abort on the last allowed WAIT cycle; a done in that same cycle still wins.
    assign w_tmo = (r_state == S_WAIT) && (r_cnt == CW'(TIMEOUT - 1));
    assign err   = r_err;
`else
    assign w_tmo = 1'b0;
    assign err   = 1'b0;
`endif

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_LOAD_A: if (w_acc) w_nxt = S_LOAD_B;
            S_LOAD_B: if (w_acc) w_nxt = S_START;
            S_START:  w_nxt = S_WAIT;
            S_WAIT: begin
                if (mul_done)   w_nxt = S_OUT_LO;
                else if (w_tmo) w_nxt = S_LOAD_A;
            end
            S_OUT_LO: if (out_ready) w_nxt = S_OUT_HI;
            S_OUT_HI: if (out_ready) w_nxt = S_LOAD_A;
            default:  w_nxt = S_LOAD_A;
        endcase
    end

    // Handshake outputs are decoded from the next state so they are registered yet
    // line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_LOAD_A;
            r_prod      <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_out_data  <= '0;
            r_in_ready  <= 1'b1;
            r_mul_start <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef MUL_SEQ_TIMEOUT_EN
            r_cnt       <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_state     <= w_nxt;
            r_in_ready  <= (w_nxt == S_LOAD_A) || (w_nxt == S_LOAD_B);
            r_mul_start <= (w_nxt == S_START);
            r_out_valid <= (w_nxt == S_OUT_LO) || (w_nxt == S_OUT_HI);
            r_busy      <= (w_nxt != S_LOAD_A);

            if (r_state == S_LOAD_A && w_acc) r_mul_a <= in_data;
            if (r_state == S_LOAD_B && w_acc) r_mul_b <= in_data;

            if (r_state == S_WAIT && mul_done) begin
                r_prod     <= mul_p;
                r_out_data <= mul_p[W-1:0];
            end
            if (r_state == S_OUT_LO && out_ready) r_out_data <= r_prod[2*W-1:W];

`ifdef MUL_SEQ_TIMEOUT_EN
            if (r_state == S_START)     r_cnt <= '0;
            else if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;

            if (r_state == S_LOAD_A && w_acc) r_err <= 1'b0;
            else if (w_tmo && !mul_done)      r_err <= 1'b1;
`endif
        end
    end

    assign in_ready  = r_in_ready;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign mul_start = r_mul_start;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mul_io_sequencer.sv
// Randomized bench for mul_io_sequencer; the bench plays source, multiplier and sink
// and predicts every word from plain arithmetic on the operands it sends.
module tb_mul_io_sequencer;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic           mul_start;
    logic           mul_done;
    logic [2*W-1:0] mul_p;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic           busy;
    logic           err;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    mul_io_sequencer #(.W(W), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
        .mul_done(mul_done), .mul_p(mul_p),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One full transaction: A, gap idle cycles, B, multiplier replies after dly
    // extra WAIT cycles, sink stalls bp cycles on the low word.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int gap, input int dly, input int bp);
        logic [2*W-1:0] p;
        int t0;
        int n;
        p = (2*W)'(a) * (2*W)'(b);
        @(negedge clk);
        in_data = a; in_valid = 1'b1; n = 0;
        while (!in_ready && n < 10) begin
            @(negedge clk); n++;
        end
        chk("a_ready", in_ready, 1);
        @(negedge clk);
        t0 = cyc - 1;
        chk("err_clear", err, 0);
        chk("b_ready", in_ready, 1);
        in_valid = 1'b0; in_data = 8'h3C;
        repeat (gap) begin
            @(negedge clk);
            chk("gap_hold", {in_ready, mul_start}, 2'b10);
        end
        in_data = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_data = 8'hC3;
        chk("start", mul_start, 1);
        chk("mul_a", mul_a, a);
        chk("mul_b", mul_b, b);
        chk("start_rdy", in_ready, 0);
        // done during START must be ignored
        mul_done = 1'b1; mul_p = 16'hDEAD;
        @(negedge clk);
        mul_done = 1'b0;
        chk("start_pulse", mul_start, 0);
        repeat (dly) begin
            @(negedge clk);
            chk("wait_nov", out_valid, 0);
        end
        mul_done = 1'b1; mul_p = p;
        @(negedge clk);
        mul_done = 1'b0; mul_p = ~p;
        chk("lo_valid", out_valid, 1);
        chk("lo_data", out_data, p[W-1:0]);
        chk("latency", cyc - t0, 4 + gap + dly);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
        repeat (bp) begin
            @(negedge clk);
            chk("bp_hold", {out_valid, out_data}, {1'b1, p[W-1:0]});
            chk("bp_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("hi_data", {out_valid, out_data}, {1'b1, p[2*W-1:W]});
        chk("hi_rdy", in_ready, 0);
        @(negedge clk);
        chk("idle", {busy, out_valid, in_ready}, 3'b001);
        chk("a_not_taken", mul_a, a);
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; mul_done = 1'b0;
        mul_p = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {in_ready, busy, out_valid, mul_start, err}, 5'b10000);
        chk("rst_data", {mul_a, mul_b, out_data}, 24'h0);
        rst = 1'b0;

        do_op(8'h0F, 8'h11, 0, 0, 0);
        do_op(8'hFF, 8'hFF, 0, 0, 0);
        do_op(8'hFF, 8'hFF, 0, 0, 3);
        do_op(8'h03, 8'h07, 5, 0, 0);

        // reset while WAITing; a late done must produce nothing
        @(negedge clk); in_data = 8'h44; in_valid = 1'b1;
        @(negedge clk); in_data = 8'h55;
        @(negedge clk); in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ctrl", {in_ready, busy, out_valid, mul_start, err}, 5'b10000);
        chk("mid_rst_data", {mul_a, mul_b, out_data}, 24'h0);
        @(negedge clk);
        rst = 1'b0; mul_done = 1'b1; mul_p = 16'h1234;
        @(negedge clk);
        mul_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_quiet", {out_valid, busy}, 2'b00);
        end
        do_op(8'h02, 8'h02, 0, 0, 0);

        for (int i = 0; i < 24; i++)
            do_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                  $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3));

`ifdef MUL_SEQ_TIMEOUT_EN
        @(negedge clk); in_data = 8'h21; in_valid = 1'b1;
        @(negedge clk); in_data = 8'h43;
        @(negedge clk); in_valid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            chk("tmo_wait", {busy, out_valid, err}, 3'b100);
        end
        @(negedge clk);
        chk("tmo_abort", {err, in_ready, busy, out_valid}, 4'b1100);
        @(negedge clk);
        chk("tmo_sticky", err, 1);
        do_op(8'h09, 8'h09, 0, 0, 0);
`else
        do_op(8'h12, 8'h34, 0, 100, 1);
        chk("no_err", err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mul_io_sequencer.md
Name: mul_io_sequencer

Overview:
Byte-stream front end for the array multiplier.
- Upstream side: accepts two W-bit operands over a valid/ready input stream.
- Multiplier side: presents the operands, pulses start, waits for done and captures the 2W-bit product.
- Downstream side: returns the product as two W-bit words, low word first, on a valid/ready output stream.
- Sits directly between the pad-level input/output buses and the multiplier core.

Parameters:
W, 8, operand width; product width is 2W.
TIMEOUT, 64, max cycles in WAIT before abort (used only with MUL_SEQ_TIMEOUT_EN).

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_data  in  W  operand word.
in_valid  in  1  in_data valid.
in_ready  out  1  sequencer can accept an operand.
mul_a  out  W  operand A to multiplier.
mul_b  out  W  operand B to multiplier.
mul_start  out  1  one-cycle start pulse.
mul_done  in  1  multiplier result valid.
mul_p  in  2W  multiplier product.
out_data  out  W  product word.
out_valid  out  1  out_data valid.
out_ready  in  1  downstream accepts.
busy  out  1  high whenever state != LOAD_A.
err  out  1  sticky timeout flag; constant 0 without the macro.

Behaviour:
- Reset, asynchronous on rst high, effective mid-operation in any state:
  - state = LOAD_A.
  - mul_a, mul_b, product register, out_data = 0.
  - mul_start, out_valid, busy, err = 0; in_ready = 1 after reset.
  - An in-flight product is discarded.
- States: LOAD_A, LOAD_B, START, WAIT, OUT_LO, OUT_HI.
- LOAD_A:
  - in_ready = 1.
  - in_valid & in_ready: mul_a <= in_data, clear err, go to LOAD_B.
- LOAD_B:
  - in_ready = 1.
  - Transfer: mul_b <= in_data, go to START.
- START:
  - mul_start = 1 for exactly this cycle; go to WAIT.
  - mul_done is ignored in START.
- WAIT:
  - mul_done sampled high: product <= mul_p, go to OUT_LO.
  - Otherwise stay in WAIT.
- OUT_LO:
  - out_valid = 1, out_data = product[W-1:0].
  - Data holds stable while out_ready is low.
  - out_ready high: go to OUT_HI.
- OUT_HI:
  - out_valid = 1, out_data = product[2W-1:W].
  - out_ready high: go to LOAD_A.
- in_ready = 0 in every state other than LOAD_A and LOAD_B; in_valid is ignored there.
- mul_a and mul_b hold stable from their load until overwritten by the next operand accept.
- Minimum latency, with A accepted at cycle N:
  - B accepted at N+1.
  - mul_start at N+2.
  - Earliest done sampled at N+3.
  - out_valid (low word) at N+4.
  - High word at N+5 if out_ready is held high.
- Gaps in in_valid simply stall LOAD_A/LOAD_B; no partial-operand timeout.
- Simultaneous out_ready and in_valid in OUT_HI: the operand is not accepted (in_ready = 0) and is taken in the following LOAD_A cycle.
- Product is unsigned; no truncation; mul_p is latched once and not re-sampled.

Optional Feature:
MUL_SEQ_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If TIMEOUT cycles elapse without mul_done: err <= 1 (sticky), go to LOAD_A, produce no output words.
  - err clears only on the next operand-A accept or on reset.
- Not defined:
  - WAIT has no limit.
  - No counter logic is built.
  - err is tied to 0.

Test Plan:
- Basic:
  - Stimulus: A = 0x0F, B = 0x11; model multiplier asserts done one cycle after start with mul_p = 0x00FF; out_ready = 1.
  - Response: out words 0xFF then 0x00; out_valid first seen 4 cycles after A accept; busy falls after the second word.
- Max operands:
  - Stimulus: A = 0xFF, B = 0xFF.
  - Response: mul_p 0xFE01 returns words 0x01, 0xFE; mul_start is high for exactly one cycle.
- Backpressure:
  - Stimulus: same as max operands; hold out_ready low 3 cycles in OUT_LO.
  - Response: out_data stays 0x01 with out_valid high; 0xFE follows only after out_ready rises; in_ready stays 0 throughout.
- Input gaps:
  - Stimulus: in_valid low 5 cycles between A = 0x03 and B = 0x07.
  - Response: START delayed accordingly; output 0x15, 0x00.
- Reset mid-WAIT:
  - Stimulus: assert rst while in WAIT; later assert mul_done.
  - Response: all outputs 0 immediately; no out_valid; next operands 0x02, 0x02 yield 0x04, 0x00.
- Timeout (macro defined, TIMEOUT = 64):
  - Stimulus: withhold mul_done.
  - Response: err = 1 and in_ready = 1 after 64 WAIT cycles; no out_valid.
  - Stimulus: next A accept.
  - Response: err clears.
